// File: rtl/mips_cpu_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op encoding, FSM states, iteration count.
package mips_cpu_pkg;

  localparam int MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  function automatic logic op_signed(muldiv_op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_div(muldiv_op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv_signfix.sv
// Conditional two's-complement negate; serves as abs() on operands and as the sign fix on results.
module mips_cpu_muldiv_signfix
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = MULDIV_ITERS
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);

  assign res = neg ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative HI/LO unit: MULT/MULTU by shift-add, DIV/DIVU by restoring division, 1 bit per cycle.
// Operands are made magnitudes on accept and the signs are re-applied in the FIX cycle.
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = MULDIV_ITERS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  muldiv_state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;     // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;    // multiplicand or divisor magnitude
  logic               is_div, neg_q, neg_r, dbz;
  logic               accept, step, fix, busy_nx, done_nx;

  // operand capture
  muldiv_op_t       op_in;
  logic             sgn_in, sa, sb;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign op_in  = muldiv_op_t'(op);
  assign sgn_in = op_signed(op_in);
  assign sa     = sgn_in & a[WIDTH-1];
  assign sb     = sgn_in & b[WIDTH-1];

  mips_cpu_muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (.val(a), .neg(sa), .res(a_abs));
  mips_cpu_muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (.val(b), .neg(sb), .res(b_abs));

  // one iteration of each algorithm
  logic [WIDTH:0]     madd, dtmp;
  logic [WIDTH-1:0]   dsub;
  logic               dge;
  logic [2*WIDTH-1:0] mult_nx, div_nx;

  assign madd    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mult_nx = {madd, acc[WIDTH-1:1]};

  assign dtmp   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign dge    = dtmp >= {1'b0, opnd};
  assign dsub   = dtmp[WIDTH-1:0] - opnd;
  assign div_nx = {(dge ? dsub : dtmp[WIDTH-1:0]), acc[WIDTH-2:0], dge};

  // result sign fix
  logic [2*WIDTH-1:0] prod_fx;
  logic [WIDTH-1:0]   quo_fx, rem_fx;

  mips_cpu_muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (.val(acc), .neg(neg_q), .res(prod_fx));
  mips_cpu_muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo
    (.val(acc[WIDTH-1:0]), .neg(neg_q), .res(quo_fx));
  mips_cpu_muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem
    (.val(acc[2*WIDTH-1:WIDTH]), .neg(neg_r), .res(rem_fx));

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs (registered below)
  always_comb begin
    accept  = (state == IDLE) && start;
    step    = (state == RUN);
    fix     = (state == FIX);
    busy_nx = (state_nx != IDLE);
    done_nx = fix;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
      if (accept) begin
        cnt    <= '0;
        is_div <= op_is_div(op_in);
        neg_q  <= sa ^ sb;
        neg_r  <= sa;
        dbz    <= op_is_div(op_in) && (b == '0);
        acc    <= {{WIDTH{1'b0}}, (op_is_div(op_in) ? a_abs : b_abs)};
        opnd   <= op_is_div(op_in) ? b_abs : a_abs;
      end else if (step) begin
        cnt <= cnt + CW'(1);
        acc <= is_div ? div_nx : mult_nx;
      end
      // restoring division by zero already leaves |a| as remainder; only LO needs forcing
      if (fix) begin
        if (is_div) begin
          hi <= rem_fx;
          lo <= dbz ? '1 : quo_fx;
        end else begin
          hi <= prod_fx[2*WIDTH-1:WIDTH];
          lo <= prod_fx[WIDTH-1:0];
        end
      end else if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule
